// File: rtl/tcp_rx_app_pkg.sv
// Shared field offsets, FSM state type and defaults for the TCP receive-side application.
// The optional TCP_RX_CHECK_EN build adds per-chunk byte and session checking.
package network_types;

  localparam int NOTIF_W            = 88;
  localparam int NOTIF_SESSION_LSB  = 0;
  localparam int NOTIF_LENGTH_LSB   = 16;
  localparam int NOTIF_IP_LSB       = 32;
  localparam int NOTIF_PORT_LSB     = 64;
  localparam int NOTIF_CLOSED_BIT   = 80;

  localparam int READ_PKG_W           = 32;
  localparam int READ_PKG_SESSION_LSB = 0;
  localparam int READ_PKG_LENGTH_LSB  = 16;

  localparam int META_W              = 16;
  localparam int DEFAULT_MAX_REQ_LEN = 1024;
  localparam int POPCNT_W            = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_META = 2'd2,
    ST_DATA = 2'd3
  } tcp_rx_state_t;

  function automatic logic [15:0] chunk_len(input logic [15:0] remaining,
                                            input logic [15:0] max_len);
    return (remaining > max_len) ? max_len : remaining;
  endfunction

endpackage

// File: rtl/tcp_rx_app_if.sv
// Stream bundle between network_stack and the receive application.
// slave = application side, master = stack side.
interface tcp_rx_app_if
  import network_types::*;
#(
  parameter int DATA_WIDTH = 512
);
  logic                      s_axis_notif_valid;
  logic                      s_axis_notif_ready;
  logic [NOTIF_W-1:0]        s_axis_notif_data;

  logic                      m_axis_read_pkg_valid;
  logic                      m_axis_read_pkg_ready;
  logic [READ_PKG_W-1:0]     m_axis_read_pkg_data;

  logic                      s_axis_rx_meta_valid;
  logic                      s_axis_rx_meta_ready;
  logic [META_W-1:0]         s_axis_rx_meta_data;

  logic                      s_axis_rx_data_valid;
  logic                      s_axis_rx_data_ready;
  logic                      s_axis_rx_data_last;
  logic [DATA_WIDTH-1:0]     s_axis_rx_data_data;
  logic [DATA_WIDTH/8-1:0]   s_axis_rx_data_keep;

  modport slave (
    input  s_axis_notif_valid, s_axis_notif_data,
    output s_axis_notif_ready,
    output m_axis_read_pkg_valid, m_axis_read_pkg_data,
    input  m_axis_read_pkg_ready,
    input  s_axis_rx_meta_valid, s_axis_rx_meta_data,
    output s_axis_rx_meta_ready,
    input  s_axis_rx_data_valid, s_axis_rx_data_last, s_axis_rx_data_data, s_axis_rx_data_keep,
    output s_axis_rx_data_ready
  );

  modport master (
    output s_axis_notif_valid, s_axis_notif_data,
    input  s_axis_notif_ready,
    input  m_axis_read_pkg_valid, m_axis_read_pkg_data,
    output m_axis_read_pkg_ready,
    output s_axis_rx_meta_valid, s_axis_rx_meta_data,
    input  s_axis_rx_meta_ready,
    output s_axis_rx_data_valid, s_axis_rx_data_last, s_axis_rx_data_data, s_axis_rx_data_keep,
    input  s_axis_rx_data_ready
  );
endinterface

// File: rtl/tcp_rx_app_keep_popcount.sv
// Counts set keep bits of one rx data beat; the consumer registers the result.
module keep_popcount #(
  parameter int KEEP_W = 64,
  parameter int CNT_W  = 7
) (
  input  logic [KEEP_W-1:0] keep,
  output logic [CNT_W-1:0]  count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_W; i++) count = count + CNT_W'(keep[i]);
  end
endmodule

// File: rtl/tcp_rx_app.sv
// Receive-side application: turns notifications into chunked read requests and drains data.
// Define TCP_RX_CHECK_EN to enable chunk length and meta session checking (err_cnt).
module tcp_rx_app
  import network_types::*;
#(
  parameter int MAX_REQ_LEN = DEFAULT_MAX_REQ_LEN,
  parameter int DATA_WIDTH  = 512
) (
  input  logic        aclk,
  input  logic        aresetn,
  tcp_rx_app_if.slave axis,
  output logic [63:0] rx_byte_cnt,
  output logic [31:0] rx_req_cnt,
  output logic [63:0] rx_cycles,
  output logic [31:0] close_cnt,
  output logic [31:0] err_cnt
);
  localparam int          KEEP_W  = DATA_WIDTH / 8;
  localparam logic [15:0] MAX_LEN = 16'(MAX_REQ_LEN);

  tcp_rx_state_t state_reg, state_next;
  logic notif_ready_reg, notif_ready_next;
  logic req_valid_reg, req_valid_next;
  logic meta_ready_reg, meta_ready_next;
  logic data_ready_reg, data_ready_next;
  logic [READ_PKG_W-1:0] req_data_reg, req_data_next;

  logic [15:0] session_reg, remaining_reg;
  logic        started_reg;
  logic [63:0] rx_byte_cnt_reg, rx_cycles_reg;
  logic [31:0] rx_req_cnt_reg, close_cnt_reg;
  logic [POPCNT_W-1:0] keep_cnt;

  logic [15:0] notif_session, notif_length, req_len;
  logic        notif_empty, notif_hs, start_hs, req_hs, meta_hs, data_hs, last_hs;

  assign notif_session = axis.s_axis_notif_data[NOTIF_SESSION_LSB +: 16];
  assign notif_length  = axis.s_axis_notif_data[NOTIF_LENGTH_LSB +: 16];
  assign notif_empty   = axis.s_axis_notif_data[NOTIF_CLOSED_BIT] || (notif_length == '0);
  assign req_len       = req_data_reg[READ_PKG_LENGTH_LSB +: 16];

  assign notif_hs = axis.s_axis_notif_valid && notif_ready_reg;
  assign start_hs = notif_hs && !notif_empty;
  assign req_hs   = req_valid_reg && axis.m_axis_read_pkg_ready;
  assign meta_hs  = axis.s_axis_rx_meta_valid && meta_ready_reg;
  assign data_hs  = axis.s_axis_rx_data_valid && data_ready_reg;
  assign last_hs  = data_hs && axis.s_axis_rx_data_last;

  keep_popcount #(.KEEP_W(KEEP_W), .CNT_W(POPCNT_W)) u_keep_popcount (
    .keep  (axis.s_axis_rx_data_keep),
    .count (keep_cnt)
  );

  // State register together with the Moore outputs registered from the next state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= ST_IDLE;
      notif_ready_reg <= 1'b0;
      req_valid_reg   <= 1'b0;
      meta_ready_reg  <= 1'b0;
      data_ready_reg  <= 1'b0;
      req_data_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      notif_ready_reg <= notif_ready_next;
      req_valid_reg   <= req_valid_next;
      meta_ready_reg  <= meta_ready_next;
      data_ready_reg  <= data_ready_next;
      req_data_reg    <= req_data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_hs) state_next = ST_REQ;
      ST_REQ:  if (req_hs)   state_next = ST_META;
      ST_META: if (meta_hs)  state_next = ST_DATA;
      ST_DATA: if (last_hs)  state_next = (remaining_reg == '0) ? ST_IDLE : ST_REQ;
      default: state_next = ST_IDLE;
    endcase
  end

  // The request word is loaded once on REQ entry so it stays stable under backpressure.
  always_comb begin
    notif_ready_next = (state_next == ST_IDLE);
    req_valid_next   = (state_next == ST_REQ);
    meta_ready_next  = (state_next == ST_META);
    data_ready_next  = (state_next == ST_DATA);
    req_data_next    = req_data_reg;
    if (state_next == ST_REQ && state_reg != ST_REQ) begin
      if (state_reg == ST_IDLE)
        req_data_next = {chunk_len(notif_length, MAX_LEN), notif_session};
      else
        req_data_next = {chunk_len(remaining_reg, MAX_LEN), session_reg};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      session_reg     <= '0;
      remaining_reg   <= '0;
      started_reg     <= 1'b0;
      rx_byte_cnt_reg <= '0;
      rx_req_cnt_reg  <= '0;
      rx_cycles_reg   <= '0;
      close_cnt_reg   <= '0;
    end else begin
      if (notif_hs && notif_empty) close_cnt_reg <= close_cnt_reg + 32'd1;
      if (start_hs) begin
        session_reg   <= notif_session;
        remaining_reg <= notif_length;
        started_reg   <= 1'b1;
      end
      if (req_hs) begin
        remaining_reg  <= remaining_reg - req_len;
        rx_req_cnt_reg <= rx_req_cnt_reg + 32'd1;
      end
      if (data_hs) rx_byte_cnt_reg <= rx_byte_cnt_reg + 64'(keep_cnt);
      if ((started_reg || start_hs) && rx_cycles_reg != '1)
        rx_cycles_reg <= rx_cycles_reg + 64'd1;
    end
  end

`ifdef TCP_RX_CHECK_EN
  logic [15:0] chunk_bytes_reg, expected_reg, chunk_total;
  logic [31:0] err_cnt_reg;

  assign chunk_total = chunk_bytes_reg + 16'(keep_cnt);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      chunk_bytes_reg <= '0;
      expected_reg    <= '0;
      err_cnt_reg     <= '0;
    end else begin
      if (req_hs) begin
        expected_reg    <= req_len;
        chunk_bytes_reg <= '0;
      end else if (data_hs) begin
        chunk_bytes_reg <= axis.s_axis_rx_data_last ? 16'd0 : chunk_total;
      end
      if (meta_hs && axis.s_axis_rx_meta_data != session_reg)
        err_cnt_reg <= err_cnt_reg + 32'd1;
      else if (last_hs && chunk_total != expected_reg)
        err_cnt_reg <= err_cnt_reg + 32'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = '0;
`endif

  assign axis.s_axis_notif_ready    = notif_ready_reg;
  assign axis.m_axis_read_pkg_valid = req_valid_reg;
  assign axis.m_axis_read_pkg_data  = req_data_reg;
  assign axis.s_axis_rx_meta_ready  = meta_ready_reg;
  assign axis.s_axis_rx_data_ready  = data_ready_reg;

  assign rx_byte_cnt = rx_byte_cnt_reg;
  assign rx_req_cnt  = rx_req_cnt_reg;
  assign rx_cycles   = rx_cycles_reg;
  assign close_cnt   = close_cnt_reg;

  // IP, port and payload bytes are not consumed here.
  logic unused_bits;
  assign unused_bits = ^{axis.s_axis_notif_data[NOTIF_W-1:NOTIF_CLOSED_BIT+1],
                         axis.s_axis_notif_data[NOTIF_CLOSED_BIT-1:NOTIF_IP_LSB],
                         axis.s_axis_rx_data_data, axis.s_axis_rx_meta_data};
endmodule

// File: doc/tcp_rx_app.md
# tcp_rx_app

Application-side receiver for the TCP stack's receive path. It consumes stack notifications, issues read-package requests (split into chunks of at most MAX_REQ_LEN bytes), drains the returned rx metadata and data, and keeps throughput counters. It connects directly to m_axis_notifications, s_axis_read_package, m_axis_rx_metadata and m_axis_rx_data of network_stack and is the consumer counterpart of the stack's receive interface.

## Interface
- MAX_REQ_LEN, 1024: largest length in bytes placed in one read-package request; power of two, 64..32768.
- DATA_WIDTH, 512: rx data width in bits; keep is DATA_WIDTH/8.
- aclk in 1: sole clock.
- aresetn in 1: asynchronous, active-low reset.
- s_axis_notif_valid/ready in/out 1; s_axis_notif_data in 88: [15:0] session, [31:16] length, [63:32] IP, [79:64] port, [80] closed.
- m_axis_read_pkg_valid/ready out/in 1; m_axis_read_pkg_data out 32: [15:0] session, [31:16] length.
- s_axis_rx_meta_valid/ready in/out 1; s_axis_rx_meta_data in 16: session.
- s_axis_rx_data_valid/ready/last in/out/in 1; s_axis_rx_data_data in DATA_WIDTH; s_axis_rx_data_keep in DATA_WIDTH/8.
- rx_byte_cnt out 64: bytes received (sum of popcount(keep)).
- rx_req_cnt out 32: read-package requests accepted by the stack.
- rx_cycles out 64: cycles since first accepted non-empty notification; saturates at all-ones.
- close_cnt out 32: notifications with closed=1 or length=0.
- err_cnt out 32: check failures (see Configuration).

## Operation
- FSM states: IDLE, REQ, META, DATA.
- IDLE: notif_ready=1. On accepted notification: if closed or length=0, increment close_cnt and stay in IDLE; otherwise latch session and remaining=length, then go to REQ.
- REQ: read_pkg_valid=1, data={min(remaining,MAX_REQ_LEN),session}. Valid and data stay stable until ready. On handshake: remaining -= chunk, rx_req_cnt++, latch chunk as expected, go to META.
- META: rx_meta_ready=1. On handshake go to DATA. A session mismatch against the latched session is a check failure.
- DATA: rx_data_ready=1. Each beat adds popcount(keep) to rx_byte_cnt and to a 16-bit per-chunk counter. On the last beat: if remaining=0 go to IDLE, else go to REQ.
- rx_cycles starts on the first accepted non-empty notification and never restarts until reset.
- All counters wrap modulo 2^width, except rx_cycles, which saturates.

## Timing
- All outputs are registered. Reset values: every valid/ready=0, read_pkg_data=0, all counters=0, FSM=IDLE.
- Ready signals are Moore functions of state and assert in the cycle after state entry.
- Cycle counts:
  - notification handshake to read_pkg_valid: 1 cycle.
  - read_pkg handshake to meta ready: 1 cycle.
  - meta handshake to data ready: 1 cycle.
  - last beat to next REQ or IDLE: 1 cycle.
- Data beats stream at 1 beat per cycle with no bubbles.
- Only one notification is in flight; further notifications are backpressured (notif_ready=0 outside IDLE).
- When aresetn asserts mid-transfer, the FSM returns to IDLE immediately and the partial chunk is abandoned; after release no ready is asserted before the first edge.
- Length 65535 with MAX_REQ_LEN=1024 gives 63 full chunks plus one 1023-byte chunk.

## Configuration
- TCP_RX_CHECK_EN defined: each chunk's byte count is compared with its requested length on the last beat, and the meta session is compared with the latched session. Each mismatch increments err_cnt by one, with at most one increment per check. Data beats after an early last are not expected.
- TCP_RX_CHECK_EN undefined: no comparators and no per-chunk counter; err_cnt is tied to 0.

## Structure
- network_types package holds:
  - notification, read-package and meta bit-field offset constants.
  - the tcp_rx_state_t enum.
  - the MAX_REQ_LEN default.
- One sub-module, keep_popcount: combinational, DATA_WIDTH/8 keep bits in, 7-bit count out, registered at its consumer.

## Test plan
- Notification {session=5, len=128}, stack returns 2 full beats -> one request {len=128, session=5}; rx_byte_cnt=128, rx_req_cnt=1, err_cnt=0, FSM back in IDLE.
- Notification len=3000 with MAX_REQ_LEN=1024 -> requests 1024, 1024, 952 in order; rx_byte_cnt=3000, rx_req_cnt=3.
- Notification with closed=1, then a second with len=0 -> close_cnt=2, no read_pkg_valid ever asserted.
- read_pkg_ready held low 10 cycles, rx_data_valid toggled every other cycle -> request data stable throughout; byte total exact; notif_ready=0 until the last beat completes.
- With TCP_RX_CHECK_EN: request 128, data last after 64 bytes, and meta session 6 instead of 5 -> err_cnt=2.
- aresetn pulsed mid-DATA -> all outputs zero during reset; next notification of len=64 completes normally with rx_byte_cnt=64.
